// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule constants, state encoding and Rcon lookup
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] AES_RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round numbers are 1-based; anything outside 1..10 contributes no constant.
    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        if (rnd == 4'd0 || rnd > 4'd10) begin
            return 8'h00;
        end
        return AES_RCON[rnd - 4'd1];
    endfunction

endpackage

// File: rtl/key_expand_round.sv
// rtl/key_expand_round.sv - one combinational AES-128 key-expansion round
module key_expand_round
    import aes_pkg::*;
(
    input  logic [3:0]           rnd,
    input  logic [AES_KEY_W-1:0] key_in,
    output logic [AES_KEY_W-1:0] key_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

    assign w0  = key_in[127:96];
    assign w1  = key_in[95:64];
    assign w2  = key_in[63:32];
    assign w3  = key_in[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    always_comb begin
        t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {aes_rcon(rnd), 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128 key-schedule controller with indexed round-key buffer
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AES_KEY_W-1:0] key_in,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic                 flush,
    input  logic [3:0]           rk_rd_idx,
    output logic [AES_KEY_W-1:0] rk_rd_data,
    output logic                 rk_rd_valid,
    output logic [3:0]           rk_count,
    output logic                 keys_done,
    output logic                 busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    state_t               state;
    logic [3:0]           rnd;
    logic [AES_KEY_W-1:0] last_key;
    logic [AES_KEY_W-1:0] next_key;
    logic [AES_KEY_W-1:0] rk_buf [NR+1];
    logic                 accept;
    logic                 expand_ok;

    assign accept    = key_valid && key_ready && !flush;
    assign expand_ok = (state == EXPAND) && (rnd != 4'd0) && (rnd <= NR_L);

    // Fed from last_key rather than the buffer so the read port stays free for the cipher.
    key_expand_round u_round (
        .rnd     (rnd),
        .key_in  (last_key),
        .key_out (next_key)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rnd       <= 4'd0;
            rk_count  <= 4'd0;
            last_key  <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            keys_done <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            rnd       <= 4'd0;
            rk_count  <= 4'd0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            keys_done <= 1'b0;
        end else if (accept) begin
            state     <= EXPAND;
            rnd       <= 4'd1;
            rk_count  <= 4'd1;
            last_key  <= key_in;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            keys_done <= 1'b0;
        end else begin
            case (state)
                EXPAND: begin
                    if (!expand_ok) begin
                        state     <= IDLE;
                        rnd       <= 4'd0;
                        rk_count  <= 4'd0;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        last_key <= next_key;
                        rk_count <= rnd + 4'd1;
                        if (rnd == NR_L) begin
                            state     <= DONE;
                            rnd       <= 4'd0;
                            key_ready <= 1'b1;
                            busy      <= 1'b0;
                            keys_done <= 1'b1;
                        end else begin
                            rnd <= rnd + 4'd1;
                        end
                    end
                end
                IDLE, DONE: ;
                default: begin
                    state     <= IDLE;
                    rnd       <= 4'd0;
                    rk_count  <= 4'd0;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                    keys_done <= 1'b0;
                end
            endcase
        end
    end

    // Stale entries are left in place; rk_count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            rk_buf[0] <= key_in;
        end else if (rst_n && !flush && expand_ok) begin
            rk_buf[rnd] <= next_key;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_rd_data  <= '0;
            rk_rd_valid <= 1'b0;
        end else begin
            rk_rd_data  <= (rk_rd_idx <= NR_L) ? rk_buf[rk_rd_idx] : '0;
            rk_rd_valid <= (rk_rd_idx < rk_count);
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl against a word-level key-schedule model
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic         flush = 1'b0;
    logic [3:0]   rk_rd_idx = 4'd0;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;
    logic [3:0]   rk_count;
    logic         keys_done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] model_rk [11];

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .flush       (flush),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid),
        .rk_count    (rk_count),
        .keys_done   (keys_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // Classic generator-3 walk: p steps through all nonzero elements, q tracks its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ 8'(q << 1);
            q = q ^ 8'(q << 2);
            q = q ^ 8'(q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic read_idx(input logic [3:0] i, output logic [127:0] d, output logic v);
        rk_rd_idx = i;
        step();
        d = rk_rd_data;
        v = rk_rd_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({key_ready, busy, keys_done, rk_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b cnt=%0d exp 1 0 0 0",
                     key_ready, busy, keys_done, rk_count);
        end
        checks++;
        if ({rk_rd_valid, rk_rd_data} !== {1'b0, 128'h0}) begin
            errors++;
            $display("FAIL reset_read got v=%b d=%h exp 0 0", rk_rd_valid, rk_rd_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fips();
        logic [127:0] d;
        logic         v;
        model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        start_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        checks++;
        if ({key_ready, busy, rk_count} !== {1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL fips_accept got rdy=%b busy=%b cnt=%0d exp 0 1 1", key_ready, busy, rk_count);
        end
        for (int c = 1; c <= 9; c++) begin
            step();
            checks++;
            if ({keys_done, rk_count} !== {1'b0, 4'(c + 1)}) begin
                errors++;
                $display("FAIL fips_progress cyc=%0d got done=%b cnt=%0d exp 0 %0d", c, keys_done, rk_count, c + 1);
            end
        end
        step();
        checks++;
        if ({keys_done, key_ready, busy, rk_count} !== {1'b1, 1'b1, 1'b0, 4'd11}) begin
            errors++;
            $display("FAIL fips_done got done=%b rdy=%b busy=%b cnt=%0d exp 1 1 0 11",
                     keys_done, key_ready, busy, rk_count);
        end
        for (int i = 0; i <= 10; i++) begin
            read_idx(4'(i), d, v);
            checks++;
            if (v !== 1'b1 || d !== model_rk[i]) begin
                errors++;
                $display("FAIL fips_entry%0d got v=%b d=%h exp 1 %h", i, v, d, model_rk[i]);
            end
        end
        read_idx(4'd1, d, v);
        checks++;
        if (d !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL fips_golden1 got %h exp a0fafe1788542cb123a339392a6c7605", d);
        end
        read_idx(4'd10, d, v);
        checks++;
        if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL fips_golden10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", d);
        end
    endtask

    task automatic test_incremental_read();
        logic [127:0] k;
        int           idx;
        int           cnt;
        int           prev;
        for (int it = 0; it < 3; it++) begin
            k   = {$urandom, $urandom, $urandom, $urandom};
            idx = $urandom_range(0, 10);
            model_expand(k);
            start_key(k);
            rk_rd_idx = 4'(idx);
            cnt = 1;
            for (int j = 1; j <= 10; j++) begin
                prev = cnt;
                step();
                cnt = j + 1;
                checks++;
                if (rk_rd_valid !== (idx < prev) || (rk_rd_valid && rk_rd_data !== model_rk[idx])) begin
                    errors++;
                    $display("FAIL incr_read idx=%0d cyc=%0d got v=%b d=%h exp v=%b d=%h",
                             idx, j, rk_rd_valid, rk_rd_data, idx < prev, model_rk[idx]);
                end
                checks++;
                if (rk_count !== 4'(cnt)) begin
                    errors++;
                    $display("FAIL incr_count cyc=%0d got %0d exp %0d", j, rk_count, cnt);
                end
            end
        end
    endtask

    task automatic test_flush_mid();
        logic [127:0] d;
        logic         v;
        start_key({$urandom, $urandom, $urandom, $urandom});
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({key_ready, busy, keys_done, rk_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_mid got rdy=%b busy=%b done=%b cnt=%0d exp 1 0 0 0",
                     key_ready, busy, keys_done, rk_count);
        end
        for (int i = 0; i <= 4; i++) begin
            read_idx(4'(i), d, v);
            checks++;
            if (v !== 1'b0) begin
                errors++;
                $display("FAIL flush_read%0d got v=%b exp 0", i, v);
            end
        end
    endtask

    task automatic test_flush_handshake();
        start_key({$urandom, $urandom, $urandom, $urandom});
        repeat (10) step();
        checks++;
        if (keys_done !== 1'b1) begin
            errors++;
            $display("FAIL flush_hs_pre got done=%b exp 1", keys_done);
        end
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        flush     = 1'b1;
        step();
        key_valid = 1'b0;
        flush     = 1'b0;
        checks++;
        if ({key_ready, busy, keys_done, rk_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_hs got rdy=%b busy=%b done=%b cnt=%0d exp 1 0 0 0",
                     key_ready, busy, keys_done, rk_count);
        end
        repeat (3) step();
        checks++;
        if ({busy, rk_count} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL flush_hs_dropped got busy=%b cnt=%0d exp 0 0", busy, rk_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        logic         v;
        start_key({$urandom, $urandom, $urandom, $urandom});
        rk_rd_idx = 4'd0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({key_ready, busy, keys_done, rk_count, rk_rd_valid, rk_rd_data} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 128'h0}) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b busy=%b done=%b cnt=%0d v=%b d=%h exp 1 0 0 0 0 0",
                     key_ready, busy, keys_done, rk_count, rk_rd_valid, rk_rd_data);
        end
        model_expand(128'h0);
        start_key(128'h0);
        repeat (10) step();
        read_idx(4'd10, d, v);
        checks++;
        if (v !== 1'b1 || d !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL zero_key_e10 got v=%b d=%h exp 1 b4ef5bcb3e92e21123e951cf6f8f188e", v, d);
        end
        read_idx(4'd5, d, v);
        checks++;
        if (d !== model_rk[5]) begin
            errors++;
            $display("FAIL zero_key_e5 got %h exp %h", d, model_rk[5]);
        end
    endtask

    task automatic test_index_oob();
        logic [127:0] d;
        logic         v;
        logic [3:0]   bad [3];
        bad[0] = 4'd12;
        bad[1] = 4'd11;
        bad[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            read_idx(bad[i], d, v);
            checks++;
            if ({v, d} !== {1'b0, 128'h0}) begin
                errors++;
                $display("FAIL oob_idx%0d got v=%b d=%h exp 0 0", bad[i], v, d);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, kb, d;
        logic         v;
        for (int it = 0; it < 2; it++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            kb = {$urandom, $urandom, $urandom, $urandom};
            model_expand(kb);
            key_in    = ka;
            key_valid = 1'b1;
            step();
            key_in = kb;
            for (int j = 0; j <= 9; j++) begin
                checks++;
                if ({key_ready, rk_count} !== {1'b0, 4'(j + 1)}) begin
                    errors++;
                    $display("FAIL hold_ignored cyc=%0d got rdy=%b cnt=%0d exp 0 %0d", j, key_ready, rk_count, j + 1);
                end
                step();
            end
            checks++;
            if ({keys_done, key_ready} !== 2'b11) begin
                errors++;
                $display("FAIL b2b_done got done=%b rdy=%b exp 1 1", keys_done, key_ready);
            end
            step();
            key_valid = 1'b0;
            checks++;
            if ({keys_done, busy, rk_count} !== {1'b0, 1'b1, 4'd1}) begin
                errors++;
                $display("FAIL b2b_accept got done=%b busy=%b cnt=%0d exp 0 1 1", keys_done, busy, rk_count);
            end
            repeat (10) step();
            for (int i = 0; i <= 10; i++) begin
                read_idx(4'(i), d, v);
                checks++;
                if (v !== 1'b1 || d !== model_rk[i]) begin
                    errors++;
                    $display("FAIL b2b_entry%0d got v=%b d=%h exp 1 %h", i, v, d, model_rk[i]);
                end
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_incremental_read();
        test_flush_mid();
        test_flush_handshake();
        test_reset_mid();
        test_index_oob();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
